// File: rtl/rom_loader_ctrl.sv
// ROM download controller: captures data_io bytes into a small FIFO and replays
// them as toggle-handshake writes on one or more sdram ports.
module rom_loader_ctrl #(
   parameter int         NUM_PORTS  = 2,
   parameter bit         MIRROR     = 1'b1,
   parameter int         SEL_BIT    = 22,
   parameter bit         PACK16     = 1'b0,
   parameter logic [7:0] ROM_INDEX  = 8'd0,
   parameter int         FIFO_DEPTH = 8
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic                 ioctl_download,
   input  logic [7:0]           ioctl_index,
   input  logic                 ioctl_wr,
   input  logic [24:0]          ioctl_addr,
   input  logic [7:0]           ioctl_dout,
   input  logic                 user_reset,
   output logic [NUM_PORTS-1:0] port_req,
   input  logic [NUM_PORTS-1:0] port_ack,
   output logic [22:0]          port_a,
   output logic [15:0]          port_d,
   output logic [1:0]           port_ds,
   output logic                 port_we,
   output logic                 rom_loaded,
   output logic                 core_reset,
   output logic                 busy,
   output logic                 overflow
);
   localparam int SELW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {SYNC, IDLE, ISSUE, WAIT} state_t;
   state_t state_q, state_d;

   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [AW:0]          wp_q, rp_q;
   logic                 fifo_empty, fifo_full, push, pop, cap, rom_dl;
   logic [23:0]          h_addr;
   logic [7:0]           h_byte;
   logic [NUM_PORTS-1:0] req_q, req_d, tmask_q, tmask_d, sel_mask;
   logic [23:0]          a_q, a_d, hold_addr_q, hold_addr_d;
   logic [15:0]          d_q, d_d;
   logic [1:0]           ds_q, ds_d;
   logic [7:0]           hold_byte_q, hold_byte_d;
   logic                 hold_vld_q, hold_vld_d;
   logic                 wr_q, rom_dl_q, ended_q, loaded_q, ovf_q, core_reset_q;
   logic                 unused_addr_msb;

   assign unused_addr_msb = ioctl_addr[24];

   assign rom_dl     = ioctl_download & (ioctl_index == ROM_INDEX);
   assign cap        = ioctl_wr & ~wr_q & rom_dl;
   assign fifo_empty = (wp_q == rp_q);
   assign fifo_full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign push       = cap & ~fifo_full;
   assign h_addr     = mem_q[rp_q[AW-1:0]][31:8];
   assign h_byte     = mem_q[rp_q[AW-1:0]][7:0];

   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wp_q[AW-1:0]] <= {ioctl_addr[23:0], ioctl_dout};
   end

   // Target ports for the write currently in the issue registers.
   always_comb begin
      sel_mask = '0;
      if (MIRROR || NUM_PORTS == 1) sel_mask = '1;
      else
         for (int i = 0; i < NUM_PORTS; i++)
            if (a_q[SEL_BIT +: SELW] == SELW'(i)) sel_mask[i] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      tmask_d     = tmask_q;
      a_d         = a_q;
      d_d         = d_q;
      ds_d        = ds_q;
      hold_vld_d  = hold_vld_q;
      hold_addr_d = hold_addr_q;
      hold_byte_d = hold_byte_q;
      pop         = 1'b0;
      case (state_q)
         SYNC: begin
            req_d   = port_ack;
            state_d = IDLE;
         end
         IDLE: begin
            if (!fifo_empty) begin
               if (!PACK16) begin
                  pop     = 1'b1;
                  a_d     = h_addr;
                  d_d     = {h_byte, h_byte};
                  ds_d    = {h_addr[0], ~h_addr[0]};
                  state_d = ISSUE;
               end else if (hold_vld_q) begin
                  // Pair with the head if it is the odd partner, else flush the held byte alone.
                  hold_vld_d = 1'b0;
                  a_d        = hold_addr_q;
                  state_d    = ISSUE;
                  if (h_addr == hold_addr_q + 24'd1) begin
                     pop  = 1'b1;
                     d_d  = {h_byte, hold_byte_q};
                     ds_d = 2'b11;
                  end else begin
                     d_d  = {hold_byte_q, hold_byte_q};
                     ds_d = 2'b01;
                  end
               end else if (!h_addr[0]) begin
                  pop         = 1'b1;
                  hold_vld_d  = 1'b1;
                  hold_addr_d = h_addr;
                  hold_byte_d = h_byte;
               end else begin
                  pop     = 1'b1;
                  a_d     = h_addr;
                  d_d     = {h_byte, h_byte};
                  ds_d    = 2'b10;
                  state_d = ISSUE;
               end
            end else if (PACK16 && hold_vld_q && !ioctl_download) begin
               hold_vld_d = 1'b0;
               a_d        = hold_addr_q;
               d_d        = {hold_byte_q, hold_byte_q};
               ds_d       = 2'b01;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (sel_mask == '0) state_d = IDLE;
            else begin
               req_d   = req_q ^ sel_mask;
               tmask_d = sel_mask;
               state_d = WAIT;
            end
         end
         WAIT: if (((req_q ^ port_ack) & tmask_q) == '0) state_d = IDLE;
         default: state_d = SYNC;
      endcase
   end

   assign busy = ~fifo_empty | hold_vld_q | (state_q == ISSUE) | (state_q == WAIT);

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q      <= SYNC;
         wp_q         <= '0;
         rp_q         <= '0;
         req_q        <= '0;
         tmask_q      <= '0;
         a_q          <= '0;
         d_q          <= '0;
         ds_q         <= '0;
         hold_vld_q   <= 1'b0;
         hold_addr_q  <= '0;
         hold_byte_q  <= '0;
         wr_q         <= 1'b0;
         rom_dl_q     <= 1'b0;
         ended_q      <= 1'b0;
         loaded_q     <= 1'b0;
         ovf_q        <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         tmask_q      <= tmask_d;
         a_q          <= a_d;
         d_q          <= d_d;
         ds_q         <= ds_d;
         hold_vld_q   <= hold_vld_d;
         hold_addr_q  <= hold_addr_d;
         hold_byte_q  <= hold_byte_d;
         wr_q         <= ioctl_wr;
         rom_dl_q     <= rom_dl;
         if (push) wp_q <= wp_q + (AW+1)'(1);
         if (pop)  rp_q <= rp_q + (AW+1)'(1);
         if (cap && fifo_full) ovf_q <= 1'b1;
         if (rom_dl_q && !ioctl_download) ended_q <= 1'b1;
         if (ended_q && !ioctl_download && !busy) loaded_q <= 1'b1;
         core_reset_q <= user_reset | ~loaded_q | rom_dl;
      end
   end

   assign port_req   = req_q;
   assign port_a     = a_q[23:1];
   assign port_d     = d_q;
   assign port_ds    = ds_q;
   assign port_we    = ioctl_download | busy;
   assign rom_loaded = loaded_q;
   assign core_reset = core_reset_q;
   assign overflow   = ovf_q;
endmodule

// File: doc/rom_loader_ctrl.md
Name: rom_loader_ctrl

Overview:
Parametrised ROM download controller between data_io (ioctl_* byte stream) and the multi-port sdram controller's toggle-handshake write ports.
- Generalises the fixed two-port mirrored download to NUM_PORTS ports.
- Adds a MIRROR/ROUTE mode, optional 16-bit byte packing, a download index filter and a byte FIFO that absorbs SDRAM back-pressure.
- Generates rom_loaded and the core reset, so every arcade top level instantiates one block instead of ad-hoc always blocks.

Parameters:
NUM_PORTS, 2, number of sdram write ports driven (1..4)
MIRROR, 1, 1 = every byte written to all ports; 0 = one port selected by address
SEL_BIT, 22, in ROUTE mode the port index is ioctl_addr[SEL_BIT +: clog2(NUM_PORTS)]
PACK16, 0, 1 = merge even/odd consecutive bytes into one 16-bit write
ROM_INDEX, 0, ioctl_index value accepted; other indices are ignored
FIFO_DEPTH, 8, entries of {addr[23:0], byte}; power of 2, minimum 2

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
ioctl_download  in  1  download active
ioctl_index  in  8  download index
ioctl_wr  in  1  byte strobe; level, may last several cycles
ioctl_addr  in  25  byte address (bits 23:0 used)
ioctl_dout  in  8  byte data
user_reset  in  1  OSD/button reset request
port_req  out  NUM_PORTS  per-port request toggle
port_ack  in  NUM_PORTS  per-port ack toggle from sdram
port_a  out  23  shared word address (byte addr[23:1])
port_d  out  16  shared write data
port_ds  out  2  shared byte strobes; [1] = odd/upper byte
port_we  out  1  high while the controller owns the ports (download or pending writes)
rom_loaded  out  1  sticky: first download of ROM_INDEX completed
core_reset  out  1  reset to the core
busy  out  1  FIFO non-empty, byte held, or a write outstanding
overflow  out  1  sticky: byte dropped because the FIFO was full

Behaviour:
- Reset values (reset_n=0):
  - port_req=0, port_a=0, port_d=0, port_ds=0, port_we=0.
  - rom_loaded=0, overflow=0, busy=0, core_reset=1.
  - FIFO emptied, any held byte discarded, FSM forced to SYNC.
- Reset mid-write abandons the write; the SDRAM write may still complete.
- Capture:
  - A rising edge of ioctl_wr is detected against a registered copy of ioctl_wr.
  - Byte is captured only if ioctl_download=1 and ioctl_index==ROM_INDEX.
  - FIFO write happens in that same cycle; one byte per edge regardless of strobe length.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky until reset).
- FSM states: SYNC, IDLE, ISSUE, WAIT.
  - SYNC: port_req<=port_ack; go to IDLE. Lasts one cycle.
  - IDLE with FIFO non-empty: pop one entry into the issue registers.
  - PACK16=0:
    - port_ds = {a[0], ~a[0]}; port_d = {byte, byte}.
    - Go to ISSUE.
  - PACK16=1, even address: hold the byte as low half, stay in IDLE.
  - PACK16=1, odd address equal to held address+1:
    - port_d = {odd, held}; port_ds = 2'b11; go to ISSUE.
  - PACK16=1, mismatch (odd with no matching held byte, or a new even byte while one is held): issue the held byte alone first (ds=01), then handle the new entry normally.
  - PACK16=1, ioctl_download falls with a byte still held: issue it as a single byte (ds=01) once the FIFO is empty.
  - ISSUE:
    - port_a = a[23:1].
    - Target mask T = all ports if MIRROR=1, else the one-hot of the select field. A select value ≥ NUM_PORTS gives an empty mask: the byte is discarded and the FSM returns to IDLE.
    - Toggle port_req[i] for every i in T; go to WAIT.
  - WAIT: return to IDLE when (port_req ^ port_ack) & T == 0. port_a, port_d and port_ds are stable from ISSUE until the WAIT exit.
- Latency: ioctl_wr rise at cycle n → FIFO write n+1 → pop n+2 → req toggle n+3, with the FIFO empty and PACK16=0.
- port_we = ioctl_download | busy.
- rom_loaded:
  - Set on the first cycle in which ioctl_download=0, busy=0, and a ROM_INDEX download has ended since reset.
  - A falling download edge with writes still pending defers the set until they drain.
- core_reset = ~reset_n | user_reset | ~rom_loaded | (ioctl_download & index==ROM_INDEX); registered, one cycle late.
- Simultaneous capture and pop in one cycle is legal; FIFO occupancy is then unchanged.

Test Plan:
1. MIRROR=1, NUM_PORTS=2, acks looped back after 3 cycles; bytes 0x11@0, 0x22@1 → two writes: a=0, ds=01, d=1111, then a=0, ds=10, d=2222; both req bits toggle each time; rom_loaded=1 once download falls and busy=0.
2. MIRROR=0, SEL_BIT=22, NUM_PORTS=2; byte 0x5A@0x400002 → only port_req[1] toggles; port_a=0x200001, ds=01; port_req[0] unchanged.
3. PACK16=1; bytes 0xAA@4, 0xBB@5, 0xCC@6, then download ends → write a=2, ds=11, d=BBAA; then a=3, ds=01, d=xxCC as a flush; rom_loaded only after the second ack.
4. FIFO_DEPTH=4, acks held off; 6 bytes streamed → 4 buffered, then overflow=1 once all FIFO entries and the issue stage are occupied; releasing acks drains the buffered bytes in address order.
5. ioctl_index=1 with ROM_INDEX=0 → no port_req activity, rom_loaded stays 0, core_reset stays 1.
6. reset_n low for one cycle during WAIT with port_ack mismatched → port_req=0, then SYNC copies port_ack so port_req==port_ack; the next byte is issued normally.
